// File: rtl/mult5_fault_campaign.sv
// Fault-campaign controller for a 5x5 multiplier: walks every fault site with stuck-at-0/1,
// sweeps operand pairs until the product diverges from golden, and reports one result per fault.
module mult5_fault_campaign #(
  parameter int NUM_SITES = 51
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  mut_a,
  output logic [4:0]  mut_b,
  output logic [50:0] mut_fault_places,
  output logic [50:0] mut_fault_control,
  input  logic [9:0]  mut_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [5:0]  res_site,
  output logic        res_stuck,
  output logic        res_detected,
  output logic [9:0]  res_vec,
  output logic [6:0]  det_count
);

  typedef enum logic [2:0] {IDLE, APPLY, CHECK, REPORT, DONE} state_e;

  state_e      state_q, state_d;
  logic [9:0]  v_q, v_d;
  logic [5:0]  site_q, site_d;
  logic        stuck_q, stuck_d;
  logic [6:0]  det_q, det_d;
  logic        detected_q, detected_d;
  logic [9:0]  vec_q, vec_d;
  logic [4:0]  a_q, b_q;
  logic [50:0] places_q, control_q;
  logic [9:0]  golden_q;
  logic [50:0] onehot_d;
  logic        last_fault;

  assign last_fault = (site_q == 6'(NUM_SITES - 1)) && stuck_q;
  assign onehot_d   = 51'(1) << site_d;

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    site_d     = site_q;
    stuck_d    = stuck_q;
    det_d      = det_q;
    detected_d = detected_q;
    vec_d      = vec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          v_d     = '0;
          site_d  = '0;
          stuck_d = 1'b0;
          det_d   = '0;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        if (mut_out != golden_q) begin
          detected_d = 1'b1;
          vec_d      = v_q;
          det_d      = det_q + 7'd1;
          state_d    = REPORT;
        end else if (v_q == 10'h3FF) begin
          detected_d = 1'b0;
          vec_d      = 10'h3FF;
          state_d    = REPORT;
        end else begin
          v_d     = v_q + 10'd1;
          state_d = APPLY;
        end
      end
      REPORT: begin
        if (res_ready) begin
          if (last_fault) begin
            state_d = DONE;
          end else begin
            if (stuck_q) begin
              stuck_d = 1'b0;
              site_d  = site_q + 6'd1;
            end else begin
              stuck_d = 1'b1;
            end
            v_d     = '0;
            state_d = APPLY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v_q        <= '0;
      site_q     <= '0;
      stuck_q    <= 1'b0;
      det_q      <= '0;
      detected_q <= 1'b0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      site_q     <= site_d;
      stuck_q    <= stuck_d;
      det_q      <= det_d;
      detected_q <= detected_d;
      vec_q      <= vec_d;
    end
  end

  // Operands, fault select and golden product load together on APPLY entry so mut_out
  // settles for a whole cycle before CHECK compares it against a matching golden value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      places_q  <= '0;
      control_q <= '0;
      golden_q  <= '0;
    end else if (state_d == APPLY) begin
      a_q       <= v_d[4:0];
      b_q       <= v_d[9:5];
      places_q  <= onehot_d;
      control_q <= stuck_d ? onehot_d : '0;
      golden_q  <= 10'(v_d[4:0]) * 10'(v_d[9:5]);
    end else if (state_d == IDLE) begin
      a_q       <= '0;
      b_q       <= '0;
      places_q  <= '0;
      control_q <= '0;
      golden_q  <= '0;
    end
  end

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign res_valid         = (state_q == REPORT);
  assign mut_a             = a_q;
  assign mut_b             = b_q;
  assign mut_fault_places  = places_q;
  assign mut_fault_control = control_q;
  assign res_site          = site_q;
  assign res_stuck         = stuck_q;
  assign res_detected      = detected_q;
  assign res_vec           = vec_q;
  assign det_count         = det_q;

endmodule
